// File: rtl/therm_n1_pkg.sv
// Shared ThermN1 types: instruction/address words, prefetch FSM states and
// the buffered {pc, inst} entry carried from memory to decode.
package therm_n1_pkg;

  typedef logic [31:0] word;
  typedef logic [63:0] addr_t;

  localparam int unsigned THERM_N1_INST_BYTES = 4;

  typedef enum logic {
    PF_RUN   = 1'b0,
    PF_FAULT = 1'b1
  } pf_state_e;

  typedef struct packed {
    addr_t pc;
    word   inst;
  } pf_entry_t;

endpackage

// File: rtl/therm_n1_sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two. Flush wins over
// push and pop in the same cycle.
module therm_n1_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_neg,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

endmodule

// File: rtl/therm_n1_prefetch.sv
// ThermN1 instruction prefetch: owns the PC, issues credit-limited word fetches
// and buffers responses for decode. THERM_N1_PREFETCH_ALIGN_CHECK_EN enables
// the misaligned-redirect fault state.
module therm_n1_prefetch
  import therm_n1_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter addr_t       RESET_PC = 64'h0
) (
  input  logic  clock,
  input  logic  reset_neg,
  output logic  mem_req_valid,
  input  logic  mem_req_ready,
  output addr_t mem_req_addr,
  input  logic  mem_rsp_valid,
  input  word   mem_rsp_data,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  inst_valid,
  input  logic  inst_ready,
  output word   inst_data,
  output addr_t inst_pc,
  output logic  misalign_fault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(pf_entry_t);

  pf_state_e     state_q, state_d;
  addr_t         pc_q, pc_d;
  addr_t         tail_pc_q, tail_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          req_fire, push, pop;
  logic          redir_misalign;
  addr_t         redir_pc;
  pf_entry_t     push_entry, head_entry;

`ifdef THERM_N1_PREFETCH_ALIGN_CHECK_EN
  assign redir_pc       = redirect_pc;
  assign redir_misalign = (redirect_pc[1:0] != 2'b00);
  assign misalign_fault = (state_q == PF_FAULT);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_pc            = {redirect_pc[63:2], 2'b00};
  assign redir_misalign      = 1'b0;
  assign misalign_fault      = 1'b0;
`endif

  // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
  assign mem_req_valid = reset_neg && (state_q == PF_RUN) && !redirect_valid &&
                         ((SW'(fifo_count) + SW'(outst_q)) < SW'(DEPTH));
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push = mem_rsp_valid && (discard_q == '0) && !redirect_valid &&
                (state_q == PF_RUN);
  assign pop  = inst_valid && inst_ready;

  assign push_entry = '{pc: tail_pc_q, inst: mem_rsp_data};

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q   <= PF_RUN;
      pc_q      <= RESET_PC;
      tail_pc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tail_pc_q <= tail_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  // tail_pc tracks the PC of the next response that will actually be kept.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tail_pc_d = tail_pc_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(mem_rsp_valid);
    discard_d = discard_q;

    if (req_fire) begin
      pc_d = pc_q + 64'(THERM_N1_INST_BYTES);
    end
    if (push) begin
      tail_pc_d = tail_pc_q + 64'(THERM_N1_INST_BYTES);
    end
    if (mem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    if (redirect_valid) begin
      pc_d      = redir_pc;
      tail_pc_d = redir_pc;
      discard_d = outst_q - CW'(mem_rsp_valid);
      state_d   = redir_misalign ? PF_FAULT : PF_RUN;
    end
  end

  therm_n1_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_neg   (reset_neg),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head_entry),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_data  = head_entry.inst;
  assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_therm_n1_prefetch.sv
// Directed bench for therm_n1_prefetch with an in-order latency-programmable
// instruction memory model.
module tb_therm_n1_prefetch;

  logic        clock = 1'b0;
  logic        reset_neg;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        misalign_fault;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int cyc      = 0;
  int bad_data = 0;

  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] acc_log[$];
  logic [63:0] del_log[$];

  therm_n1_prefetch dut (
    .clock          (clock),
    .reset_neg      (reset_neg),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_fault (misalign_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [63:0] q0(input logic [63:0] q[$]);
    return (q.size() > 0) ? q[0] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic int seq_err(input logic [63:0] q[$], input logic [63:0] base);
    int err = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] !== base + 64'(4 * i)) err++;
    end
    return err;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model and delivery monitor, sampled on the active edge.
  always @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (mem_rsp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        mq_addr.push_back(mem_req_addr);
        mq_due.push_back(cyc + lat);
        acc_log.push_back(mem_req_addr);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        del_log.push_back(inst_pc);
        if (inst_data !== inst_of(inst_pc)) bad_data++;
      end
      cyc++;
    end
  end

  always @(negedge clock) begin
    if (reset_neg && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inst_of(mq_addr[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  end

  task automatic do_reset(input int l, input logic rdy);
    @(negedge clock);
    reset_neg      = 1'b0;
    lat            = l;
    inst_ready     = rdy;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clock);
    acc_log.delete();
    del_log.delete();
    bad_data  = 0;
    reset_neg = 1'b1;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    chk("no_req_in_redirect", 64'(mem_req_valid), 64'd0);
    acc_log.delete();
    del_log.delete();
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_neg      = 1'b0;
    mem_req_ready  = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req_valid",  64'(mem_req_valid),  64'd0);
    chk("rst_inst_valid", 64'(inst_valid),     64'd0);
    chk("rst_req_addr",   mem_req_addr,        64'h0);
    chk("rst_fault",      64'(misalign_fault), 64'd0);
    chk("rst_inst_pc",    inst_pc,             64'h0);
    chk("rst_inst_data",  64'(inst_data),      64'h0);

    // Streaming, latency 1, decode always ready
    do_reset(1, 1'b1);
    #1;
    chk("first_req_valid", 64'(mem_req_valid), 64'd1);
    chk("first_req_addr",  mem_req_addr,       64'h0);
    repeat (20) @(negedge clock);
    chk("stream_acc_n",   64'(acc_log.size()),        64'd20);
    chk("stream_del_n",   64'(del_log.size()),        64'd18);
    chk("stream_acc_seq", 64'(seq_err(acc_log, 0)),   64'd0);
    chk("stream_del_seq", 64'(seq_err(del_log, 0)),   64'd0);
    chk("stream_data",    64'(bad_data),              64'd0);

    // Asynchronous reset mid-operation
    @(negedge clock);
    reset_neg = 1'b0;
    #1;
    chk("midrst_inst_valid", 64'(inst_valid),    64'd0);
    chk("midrst_req_valid",  64'(mem_req_valid), 64'd0);
    chk("midrst_req_addr",   mem_req_addr,       64'h0);

    // Decode stalled: credit limit of DEPTH
    do_reset(1, 1'b0);
    repeat (10) @(negedge clock);
    #1;
    chk("stall_acc_n",      64'(acc_log.size()), 64'd4);
    chk("stall_req_valid",  64'(mem_req_valid),  64'd0);
    chk("stall_inst_valid", 64'(inst_valid),     64'd1);
    chk("stall_head_pc",    inst_pc,             64'h0);
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    #1;
    chk("stall_refill_valid", 64'(mem_req_valid), 64'd1);
    chk("stall_refill_addr",  mem_req_addr,       64'h10);
    chk("stall_head_after",   inst_pc,            64'h4);
    repeat (5) @(negedge clock);
    #1;
    chk("stall_acc_n2",     64'(acc_log.size()), 64'd5);
    chk("stall_req_valid2", 64'(mem_req_valid),  64'd0);

    // Redirect with 3 outstanding, latency 5
    do_reset(5, 1'b1);
    repeat (3) @(negedge clock);
    #1;
    chk("lat5_acc_n", 64'(acc_log.size()), 64'd3);
    redirect_to(64'h1000);
    chk("rdr_inst_valid", 64'(inst_valid),    64'd0);
    chk("rdr_req_addr",   mem_req_addr,       64'h1000);
    chk("rdr_req_valid",  64'(mem_req_valid), 64'd1);
    repeat (30) @(negedge clock);
    chk("rdr_del_some",  64'(del_log.size() != 0),      64'd1);
    chk("rdr_first_pc",  q0(del_log),                   64'h1000);
    chk("rdr_del_seq",   64'(seq_err(del_log, 64'h1000)), 64'd0);
    chk("rdr_acc_seq",   64'(seq_err(acc_log, 64'h1000)), 64'd0);
    chk("rdr_data",      64'(bad_data),                 64'd0);

    // Redirect coinciding with a response and a pop (latency 2 steady state)
    do_reset(2, 1'b1);
    repeat (10) @(negedge clock);
    #1;
    chk("coin_pre_inst_valid", 64'(inst_valid), 64'd1);
    chk("coin_pre_rsp_pop",    64'(mem_rsp_valid && inst_ready), 64'd1);
    redirect_to(64'h3000);
    chk("coin_inst_valid", 64'(inst_valid), 64'd0);
    repeat (15) @(negedge clock);
    chk("coin_first_pc", q0(del_log),                     64'h3000);
    chk("coin_del_seq",  64'(seq_err(del_log, 64'h3000)), 64'd0);
    chk("coin_data",     64'(bad_data),                   64'd0);

    // PC wrap at the top of the address space
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr",  mem_req_addr,       64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_valid", 64'(mem_req_valid), 64'd1);
    @(negedge clock);
    #1;
    chk("wrap_next_addr", mem_req_addr, 64'h0);
    repeat (10) @(negedge clock);
    chk("wrap_first_pc", q0(del_log), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_del_seq",  64'(seq_err(del_log, 64'hFFFF_FFFF_FFFF_FFFC)), 64'd0);

    // Misaligned redirect
`ifdef THERM_N1_PREFETCH_ALIGN_CHECK_EN
    redirect_to(64'h1002);
    chk("mis_fault",     64'(misalign_fault), 64'd1);
    chk("mis_req_valid", 64'(mem_req_valid),  64'd0);
    repeat (6) @(negedge clock);
    #1;
    chk("mis_acc_n",      64'(acc_log.size()), 64'd0);
    chk("mis_inst_valid", 64'(inst_valid),     64'd0);
    chk("mis_fault_hold", 64'(misalign_fault), 64'd1);
    redirect_to(64'h2000);
    chk("mis_clear",      64'(misalign_fault), 64'd0);
    chk("mis_resume_addr", mem_req_addr,       64'h2000);
    chk("mis_resume_vld", 64'(mem_req_valid),  64'd1);
    repeat (8) @(negedge clock);
    chk("mis_first_pc", q0(del_log), 64'h2000);
`else
    redirect_to(64'h1002);
    chk("mis_fault_tied", 64'(misalign_fault), 64'd0);
    chk("mis_forced_addr", mem_req_addr,       64'h1000);
    chk("mis_req_valid",  64'(mem_req_valid),  64'd1);
    repeat (8) @(negedge clock);
    chk("mis_first_pc", q0(del_log), 64'h1000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
